// File: rtl/mem_stage_mw_if.sv
// EX/MEM -> MEM stage -> MEM/WB bus: EX/MEM register contents in, stall and
// branch select back upstream, MEM/WB pipeline registers out.
interface mem_stage_mw_if #(
  parameter int N = 32
);
  localparam int RW = $clog2(N);

  logic          in_valid;
  logic          branch;
  logic          zero;
  logic          mem_read;
  logic          mem_write;
  logic [1:0]    mem_size;
  logic          mem_unsigned;
  logic [N-1:0]  alu_out;
  logic [N-1:0]  write_data;
  logic [RW-1:0] write_reg;
  logic          mem_to_reg_mem;
  logic          reg_write_mem;

  logic          stall_out;
  logic          pc_sel_mem;
  logic [N-1:0]  read_data_mem;
  logic [N-1:0]  alu_out_mem;
  logic [RW-1:0] write_reg_mem;
  logic          mem_to_reg_wb;
  logic          reg_write_wb;
  logic          wb_valid;
  logic          misalign_wb;

  modport master (
    output in_valid, branch, zero, mem_read, mem_write, mem_size, mem_unsigned,
           alu_out, write_data, write_reg, mem_to_reg_mem, reg_write_mem,
    input  stall_out, pc_sel_mem, read_data_mem, alu_out_mem, write_reg_mem,
           mem_to_reg_wb, reg_write_wb, wb_valid, misalign_wb
  );

  modport slave (
    input  in_valid, branch, zero, mem_read, mem_write, mem_size, mem_unsigned,
           alu_out, write_data, write_reg, mem_to_reg_mem, reg_write_mem,
    output stall_out, pc_sel_mem, read_data_mem, alu_out_mem, write_reg_mem,
           mem_to_reg_wb, reg_write_wb, wb_valid, misalign_wb
  );
endinterface

// File: rtl/mem_stage_mw.sv
// MIPS MEM stage with byte/half/word data memory, configurable wait cycles,
// misalignment flagging, branch resolution and the MEM/WB pipeline registers.
module mem_stage_mw #(
  parameter int N       = 32,
  parameter int N_REG   = 256,
  parameter int MEM_LAT = 2
) (
  input logic            clk,
  input logic            reset,
  mem_stage_mw_if.slave  bus
);
  localparam int OB = $clog2(N / 8);
  localparam int AW = $clog2(N_REG);
  localparam int NB = N / 8;
  localparam int CW = $clog2(MEM_LAT + 2);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  mem [N_REG];

  logic [AW-1:0] idx;
  logic [OB-1:0] off;
  logic          access, is_load, is_store, misaligned, aligned_access;
  logic          write_en;
  logic [NB-1:0] be;
  logic [N-1:0]  wlanes;
  logic [N-1:0]  rd_word;
  logic [15:0]   low16;
  logic [N-1:0]  load_val;

  assign idx            = bus.alu_out[OB +: AW];
  assign off            = bus.alu_out[OB-1:0];
  assign access         = bus.in_valid & (bus.mem_read | bus.mem_write);
  assign is_load        = access & bus.mem_read;
  assign is_store       = access & bus.mem_write & ~bus.mem_read;
  assign aligned_access = access & ~misaligned;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    misaligned = 1'b0;
    be         = '0;
    wlanes     = bus.write_data;
    case (bus.mem_size)
      2'b00: begin
        be[off] = 1'b1;
        wlanes  = {NB{bus.write_data[7:0]}};
      end
      2'b01: begin
        misaligned = access & off[0];
        be[off]    = 1'b1;
        be[off|1]  = 1'b1;
        wlanes     = {(N/16){bus.write_data[15:0]}};
      end
      default: begin
        misaligned = access & (off != '0);
        be         = '1;
      end
    endcase
  end

  // The presentation cycle is the first wait cycle, so stall starts combinationally.
  assign bus.stall_out  = ((MEM_LAT > 0) && state == IDLE && aligned_access) || state == WAIT;
  assign bus.pc_sel_mem = bus.branch & bus.zero & bus.in_valid & ~bus.stall_out;

  assign write_en = is_store & ~misaligned & ~bus.stall_out & ~reset;

  // NOTE: data memory has no reset; contents survive reset and only stores change them.
  always_ff @(posedge clk) begin
    if (write_en) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem[idx][i*8 +: 8] <= wlanes[i*8 +: 8];
      end
    end
  end

  assign rd_word = mem[idx];
  assign low16   = 16'(rd_word >> {off, 3'b000});

  always_comb begin
    case (bus.mem_size)
      2'b00:   load_val = {{(N-8){low16[7] & ~bus.mem_unsigned}}, low16[7:0]};
      2'b01:   load_val = {{(N-16){low16[15] & ~bus.mem_unsigned}}, low16};
      default: load_val = rd_word;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      cnt               <= '0;
      bus.read_data_mem <= '0;
      bus.alu_out_mem   <= '0;
      bus.write_reg_mem <= '0;
      bus.mem_to_reg_wb <= 1'b0;
      bus.reg_write_wb  <= 1'b0;
      bus.wb_valid      <= 1'b0;
      bus.misalign_wb   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.stall_out) begin
          state <= (MEM_LAT > 1) ? WAIT : DONE;
          cnt   <= CW'(MEM_LAT - 1);
        end
        // WAIT covers the remaining MEM_LAT-1 wait cycles and exits on the last one.
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (!bus.stall_out) begin
        bus.read_data_mem <= (is_load & ~misaligned) ? load_val : '0;
        bus.alu_out_mem   <= bus.alu_out;
        bus.write_reg_mem <= bus.write_reg;
        bus.mem_to_reg_wb <= bus.mem_to_reg_mem;
        bus.reg_write_wb  <= bus.reg_write_mem & bus.in_valid & ~misaligned;
        bus.wb_valid      <= bus.in_valid;
        bus.misalign_wb   <= misaligned;
      end else begin
        bus.mem_to_reg_wb <= 1'b0;
        bus.reg_write_wb  <= 1'b0;
        bus.wb_valid      <= 1'b0;
        bus.misalign_wb   <= 1'b0;
      end
    end
  end
endmodule
